// File: rtl/us_arp_tx_pkg.sv
// Shared constants and field record for the ARP transmit path.
package us_arp_tx_pkg;

  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;

  localparam int unsigned ARP_FRAME_BEATS = 8;
  localparam logic [AXIS_KEEP_W-1:0] ARP_LAST_KEEP = 8'h0F;

  // Everything captured at acceptance; the frame is rebuilt from this alone.
  typedef struct packed {
    logic [15:0] op;
    logic [47:0] tgt_mac;
    logic [31:0] tgt_ip;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
  } arp_fields_t;

endpackage

// File: rtl/us_arp_tx_if.sv
// AXI-Stream transmit bundle between the ARP generator and the MAC.
interface us_arp_tx_if;
  import us_arp_tx_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tvalid;
  logic                   tlast;
  logic                   tuser;
  logic                   tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/us_arp_tx.sv
// ARP request/reply frame generator: one 60-byte frame per accepted request,
// streamed as 8 x 64-bit AXIS beats with a configurable inter-frame gap.
module us_arp_tx
  import us_arp_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic        rx_axis_aclk,
  input  logic        rx_axis_aresetn,
  input  logic [47:0] local_mac_addr,
  input  logic [31:0] local_ip_addr,
  input  logic [31:0] dst_ip_addr,
  input  logic        arp_request_req,
  output logic        arp_request_ack,
  input  logic        arp_reply_req,
  output logic        arp_reply_ack,
  input  logic [47:0] recv_src_mac_addr,
  input  logic [31:0] recv_src_ip_addr,
  us_arp_tx_if.master tx_axis
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam logic [2:0] LastBeat = 3'(ARP_FRAME_BEATS - 1);
  localparam logic [3:0] GapLast  = (IFG_CYCLES == 0) ? 4'd0 : 4'(IFG_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [3:0]  gap_q, gap_d;
  arp_fields_t fields_q, fields_d;
  logic        req_ack_q, req_ack_d;
  logic        rep_ack_q, rep_ack_d;

  logic        tvalid;
  logic [47:0] eth_dst;
  logic [7:0]  frame_b [64];
  logic [63:0] beat_data;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    fields_d  = fields_q;
    req_ack_d = 1'b0;
    rep_ack_d = 1'b0;
    case (state_q)
      StIdle: begin
        // Replies take priority; a concurrent request stays pending on its level.
        if (arp_reply_req) begin
          fields_d  = '{op: ARP_OP_REPLY, tgt_mac: recv_src_mac_addr,
                        tgt_ip: recv_src_ip_addr, src_mac: local_mac_addr,
                        src_ip: local_ip_addr};
          rep_ack_d = 1'b1;
          beat_d    = '0;
          state_d   = StSend;
        end else if (arp_request_req) begin
          fields_d  = '{op: ARP_OP_REQUEST, tgt_mac: 48'h0, tgt_ip: dst_ip_addr,
                        src_mac: local_mac_addr, src_ip: local_ip_addr};
          req_ack_d = 1'b1;
          beat_d    = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (tx_axis.tready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            gap_d   = '0;
            state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StGap: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      gap_q     <= '0;
      fields_q  <= '0;
      req_ack_q <= 1'b0;
      rep_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      fields_q  <= fields_d;
      req_ack_q <= req_ack_d;
      rep_ack_q <= rep_ack_d;
    end
  end

  // Byte n of the frame lives at frame_b[n]; bytes 42..63 stay zero (padding).
  always_comb begin
    eth_dst = (fields_q.op == ARP_OP_REQUEST) ? 48'hFFFF_FFFF_FFFF : fields_q.tgt_mac;
    frame_b = '{default: 8'h00};
    for (int i = 0; i < 6; i++) begin
      frame_b[i]      = eth_dst[47-8*i -: 8];
      frame_b[6 + i]  = fields_q.src_mac[47-8*i -: 8];
      frame_b[22 + i] = fields_q.src_mac[47-8*i -: 8];
      frame_b[32 + i] = fields_q.tgt_mac[47-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      frame_b[28 + i] = fields_q.src_ip[31-8*i -: 8];
      frame_b[38 + i] = fields_q.tgt_ip[31-8*i -: 8];
    end
    frame_b[12] = ETHERTYPE_ARP[15:8];
    frame_b[13] = ETHERTYPE_ARP[7:0];
    frame_b[14] = ARP_HTYPE_ETH[15:8];
    frame_b[15] = ARP_HTYPE_ETH[7:0];
    frame_b[16] = ETHERTYPE_IPV4[15:8];
    frame_b[17] = ETHERTYPE_IPV4[7:0];
    frame_b[18] = ARP_HLEN;
    frame_b[19] = ARP_PLEN;
    frame_b[20] = fields_q.op[15:8];
    frame_b[21] = fields_q.op[7:0];
  end

  always_comb begin
    beat_data = '0;
    for (int n = 0; n < 8; n++) begin
      beat_data[8*n +: 8] = frame_b[{beat_q, 3'(n)}];
    end
  end

  assign tvalid          = (state_q == StSend);
  assign tx_axis.tvalid  = tvalid;
  assign tx_axis.tdata   = tvalid ? beat_data : '0;
  assign tx_axis.tkeep   = !tvalid ? '0 : ((beat_q == LastBeat) ? ARP_LAST_KEEP : '1);
  assign tx_axis.tlast   = tvalid && (beat_q == LastBeat);
  assign tx_axis.tuser   = 1'b0;
  assign arp_request_ack = req_ack_q;
  assign arp_reply_ack   = rep_ack_q;

endmodule

// File: tb/tb_us_arp_tx.sv
// Self-checking bench for us_arp_tx: directed table, corner sequences, random frames.
module tb_us_arp_tx;

  typedef logic [7:0]  frame_t [60];
  typedef logic [63:0] beats_t [8];

  typedef struct {
    bit          reply;
    logic [47:0] lmac;
    logic [31:0] lip;
    logic [47:0] pmac;
    logic [31:0] pip;
    logic [63:0] exp_b0;
    logic [63:0] exp_b2;
    logic [63:0] exp_b4;
    logic [63:0] exp_b5;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic [31:0] dst_ip;
  logic        req_req;
  logic        req_ack;
  logic        rep_req;
  logic        rep_ack;
  logic [47:0] recv_mac;
  logic [31:0] recv_ip;

  int vectors = 0;
  int miscompares = 0;
  int rep_ack_cnt = 0;
  int req_ack_cnt = 0;

  us_arp_tx_if axis ();

  us_arp_tx #(.IFG_CYCLES(2)) dut (
    .rx_axis_aclk     (clk),
    .rx_axis_aresetn  (rst_n),
    .local_mac_addr   (local_mac),
    .local_ip_addr    (local_ip),
    .dst_ip_addr      (dst_ip),
    .arp_request_req  (req_req),
    .arp_request_ack  (req_ack),
    .arp_reply_req    (rep_req),
    .arp_reply_ack    (rep_ack),
    .recv_src_mac_addr(recv_mac),
    .recv_src_ip_addr (recv_ip),
    .tx_axis          (axis)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rep_ack) rep_ack_cnt++;
    if (req_ack) req_ack_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference frame built as one big-endian byte string from the ARP layout.
  function automatic frame_t model_frame(input bit reply, input logic [47:0] lmac,
                                         input logic [31:0] lip, input logic [47:0] pmac,
                                         input logic [31:0] pip);
    frame_t       f;
    logic [479:0] be;
    logic [47:0]  dst;
    logic [47:0]  tmac;
    logic [15:0]  op;
    dst  = reply ? pmac : 48'hFFFF_FFFF_FFFF;
    tmac = reply ? pmac : 48'h0;
    op   = reply ? 16'h0002 : 16'h0001;
    be = {dst, lmac, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, op, lmac, lip, tmac, pip,
          144'h0};
    for (int n = 0; n < 60; n++) f[n] = be[479-8*n -: 8];
    return f;
  endfunction

  function automatic logic [63:0] model_beat(input frame_t f, input int b);
    logic [63:0] w;
    w = '0;
    for (int n = 0; n < 8; n++) begin
      if (8*b + n < 60) w[8*n +: 8] = f[8*b + n];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the chosen request, expect the matching ack alongside beat 0.
  task automatic start_frame(input bit reply, input bit hold, input string tag);
    if (reply) rep_req = 1'b1;
    else       req_req = 1'b1;
    step();
    check($sformatf("%s rep_ack", tag), 64'(rep_ack), 64'(reply));
    check($sformatf("%s req_ack", tag), 64'(req_ack), 64'(!reply));
    check($sformatf("%s tvalid at start", tag), 64'(axis.tvalid), 64'd1);
    if (!hold) begin
      rep_req = 1'b0;
      req_req = 1'b0;
    end
  endtask

  task automatic collect(input frame_t f, input int stall_a, input int stall_b,
                         input int stall_len, input string tag, output beats_t got);
    int waited;
    waited = 0;
    for (int b = 0; b < 8; b++) got[b] = '0;
    while (!axis.tvalid && waited < 20) begin
      step();
      waited++;
    end
    if (!axis.tvalid) begin
      check($sformatf("%s frame start", tag), 64'(axis.tvalid), 64'd1);
      return;
    end
    for (int b = 0; b < 8; b++) begin
      if (b == stall_a || b == stall_b) begin
        axis.tready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          check($sformatf("%s hold tvalid b%0d", tag, b), 64'(axis.tvalid), 64'd1);
          check($sformatf("%s hold tdata b%0d", tag, b), axis.tdata, model_beat(f, b));
        end
        axis.tready = 1'b1;
      end
      got[b] = axis.tdata;
      check($sformatf("%s tvalid b%0d", tag, b), 64'(axis.tvalid), 64'd1);
      check($sformatf("%s tdata b%0d", tag, b), axis.tdata, model_beat(f, b));
      check($sformatf("%s tkeep b%0d", tag, b), 64'(axis.tkeep),
            (b == 7) ? 64'h0F : 64'hFF);
      check($sformatf("%s tlast b%0d", tag, b), 64'(axis.tlast), 64'(b == 7));
      step();
    end
    check($sformatf("%s tvalid after last", tag), 64'(axis.tvalid), 64'd0);
  endtask

  initial begin
    vec_t   tbl [4];
    frame_t f;
    beats_t got;
    int     exp_rep;
    int     exp_req;
    int     gap;

    tbl[0] = '{reply: 1'b1, lmac: 48'h000A35010203, lip: 32'hC0A8017B,
               pmac: 48'hAC147445BCF4, pip: 32'hC0A80165,
               exp_b0: 64'h0A00F4BC457414AC, exp_b2: 64'h0A00020004060008,
               exp_b4: 64'hA8C0F4BC457414AC, exp_b5: 64'h0000000000006501};
    tbl[1] = '{reply: 1'b0, lmac: 48'h000A35010203, lip: 32'hC0A8017B,
               pmac: 48'h0, pip: 32'hC0A80165,
               exp_b0: 64'h0A00FFFFFFFFFFFF, exp_b2: 64'h0A00010004060008,
               exp_b4: 64'hA8C0000000000000, exp_b5: 64'h0000000000006501};
    tbl[2] = '{reply: 1'b1, lmac: 48'h020000000001, lip: 32'h0A000001,
               pmac: 48'h112233445566, pip: 32'h0A000002,
               exp_b0: 64'h0002665544332211, exp_b2: 64'h0002020004060008,
               exp_b4: 64'h000A665544332211, exp_b5: 64'h0000000000000200};
    tbl[3] = '{reply: 1'b0, lmac: 48'h020000000001, lip: 32'h0A000001,
               pmac: 48'h0, pip: 32'h0A000002,
               exp_b0: 64'h0002FFFFFFFFFFFF, exp_b2: 64'h0002010004060008,
               exp_b4: 64'h000A000000000000, exp_b5: 64'h0000000000000200};

    rst_n       = 1'b0;
    local_mac   = '0;
    local_ip    = '0;
    dst_ip      = '0;
    req_req     = 1'b0;
    rep_req     = 1'b0;
    recv_mac    = '0;
    recv_ip     = '0;
    axis.tready = 1'b1;
    exp_rep     = 0;
    exp_req     = 0;

    repeat (3) step();
    check("reset tvalid", 64'(axis.tvalid), 64'd0);
    check("reset tdata", axis.tdata, 64'd0);
    check("reset tkeep", 64'(axis.tkeep), 64'd0);
    check("reset tlast", 64'(axis.tlast), 64'd0);
    check("reset tuser", 64'(axis.tuser), 64'd0);
    check("reset acks", {62'd0, rep_ack, req_ack}, 64'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      local_mac = tbl[i].lmac;
      local_ip  = tbl[i].lip;
      if (tbl[i].reply) begin
        recv_mac = tbl[i].pmac;
        recv_ip  = tbl[i].pip;
      end else begin
        dst_ip = tbl[i].pip;
      end
      start_frame(tbl[i].reply, 1'b0, $sformatf("tbl%0d", i));
      if (tbl[i].reply) exp_rep++;
      else              exp_req++;
      f = model_frame(tbl[i].reply, tbl[i].lmac, tbl[i].lip, tbl[i].pmac, tbl[i].pip);
      collect(f, -1, -1, 0, $sformatf("tbl%0d", i), got);
      check($sformatf("tbl%0d beat0", i), got[0], tbl[i].exp_b0);
      check($sformatf("tbl%0d beat2", i), got[2], tbl[i].exp_b2);
      check($sformatf("tbl%0d beat4", i), got[4], tbl[i].exp_b4);
      check($sformatf("tbl%0d beat5", i), got[5], tbl[i].exp_b5);
      repeat (3) step();
    end
    check("tbl reply ack count", 64'(rep_ack_cnt), 64'(exp_rep));
    check("tbl request ack count", 64'(req_ack_cnt), 64'(exp_req));

    // Backpressure on beats 3 and 7.
    local_mac = 48'h000A35010203;
    local_ip  = 32'hC0A8017B;
    dst_ip    = 32'hC0A80165;
    start_frame(1'b0, 1'b0, "bp");
    exp_req++;
    f = model_frame(1'b0, local_mac, local_ip, 48'h0, dst_ip);
    collect(f, 3, 7, 5, "bp", got);
    repeat (3) step();
    check("bp request ack count", 64'(req_ack_cnt), 64'(exp_req));

    // Simultaneous reply and request: reply first, request after the gap.
    recv_mac = 48'hAC147445BCF4;
    recv_ip  = 32'hC0A80165;
    dst_ip   = 32'hC0A80199;
    req_req  = 1'b1;
    start_frame(1'b1, 1'b1, "both");
    rep_req = 1'b0;
    exp_rep++;
    f = model_frame(1'b1, local_mac, local_ip, recv_mac, recv_ip);
    collect(f, -1, -1, 0, "both reply", got);
    check("both no req ack during reply", 64'(req_ack_cnt), 64'(exp_req));
    gap = 0;
    while (!axis.tvalid && gap < 20) begin
      step();
      gap++;
    end
    check("both dead cycles", 64'(gap), 64'd3);
    check("both req_ack", 64'(req_ack), 64'd1);
    req_req = 1'b0;
    exp_req++;
    f = model_frame(1'b0, local_mac, local_ip, 48'h0, dst_ip);
    collect(f, -1, -1, 0, "both request", got);
    repeat (3) step();
    check("both reply ack count", 64'(rep_ack_cnt), 64'(exp_rep));
    check("both request ack count", 64'(req_ack_cnt), 64'(exp_req));

    // Reset while beat 4 is on the bus, request held pending.
    dst_ip = 32'hC0A80142;
    start_frame(1'b0, 1'b1, "rst");
    exp_req++;
    f = model_frame(1'b0, local_mac, local_ip, 48'h0, dst_ip);
    repeat (4) step();
    check("rst pre beat4", axis.tdata, model_beat(f, 4));
    rst_n = 1'b0;
    #1;
    check("rst tvalid", 64'(axis.tvalid), 64'd0);
    check("rst tdata", axis.tdata, 64'd0);
    check("rst tkeep", 64'(axis.tkeep), 64'd0);
    check("rst tlast", 64'(axis.tlast), 64'd0);
    check("rst acks", {62'd0, rep_ack, req_ack}, 64'd0);
    step();
    step();
    check("rst held tvalid", 64'(axis.tvalid), 64'd0);
    rst_n = 1'b1;
    step();
    check("rst reaccept req_ack", 64'(req_ack), 64'd1);
    check("rst reaccept tvalid", 64'(axis.tvalid), 64'd1);
    req_req = 1'b0;
    exp_req++;
    collect(f, -1, -1, 0, "rst after", got);
    repeat (3) step();
    check("rst request ack count", 64'(req_ack_cnt), 64'(exp_req));

    // Random frames with input scrambling after acceptance.
    for (int i = 0; i < 24; i++) begin
      bit          reply;
      logic [47:0] lmac;
      logic [31:0] lip;
      logic [47:0] pmac;
      logic [31:0] pip;
      reply     = 1'($urandom_range(0, 1));
      lmac      = {16'($urandom), $urandom};
      lip       = $urandom;
      pmac      = {16'($urandom), $urandom};
      pip       = $urandom;
      local_mac = lmac;
      local_ip  = lip;
      if (reply) begin
        recv_mac = pmac;
        recv_ip  = pip;
      end else begin
        dst_ip = pip;
      end
      start_frame(reply, 1'b0, $sformatf("rnd%0d", i));
      if (reply) exp_rep++;
      else       exp_req++;
      f = model_frame(reply, lmac, lip, pmac, pip);
      local_mac = {16'($urandom), $urandom};
      local_ip  = $urandom;
      dst_ip    = $urandom;
      recv_mac  = {16'($urandom), $urandom};
      recv_ip   = $urandom;
      collect(f, $urandom_range(0, 8), -1, $urandom_range(1, 3), $sformatf("rnd%0d", i),
              got);
      repeat (3) step();
    end
    check("rnd reply ack count", 64'(rep_ack_cnt), 64'(exp_rep));
    check("rnd request ack count", 64'(req_ack_cnt), 64'(exp_req));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/us_arp_tx.md
US_ARP_TX -- requirements
Module: us_arp_tx

Interface
REQ-001 Parameter IFG_CYCLES, default 2, idle cycles forced between consecutive frames (0..15).
REQ-002 rx_axis_aclk  in  1  clock; all logic on rising edge.
REQ-003 rx_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-004 local_mac_addr  in  48  own MAC, bit47 = first transmitted byte.
REQ-005 local_ip_addr  in  32  own IP, bit31 = first transmitted byte.
REQ-006 dst_ip_addr  in  32  peer IP targeted by ARP requests.
REQ-007 arp_request_req  in  1  level; request to send ARP request (who-has dst_ip_addr).
REQ-008 arp_request_ack  out  1  one-cycle pulse: request accepted.
REQ-009 arp_reply_req  in  1  level; ARP receiver asks for a reply.
REQ-010 arp_reply_ack  out  1  one-cycle pulse: reply accepted.
REQ-011 recv_src_mac_addr  in  48  requester MAC (reply target).
REQ-012 recv_src_ip_addr  in  32  requester IP (reply target).
REQ-013 tx_axis_tdata  out  64  frame data; byte n of beat at [8n+7:8n].
REQ-014 tx_axis_tkeep  out  8  byte enables.
REQ-015 tx_axis_tvalid / tx_axis_tlast / tx_axis_tuser  out  1 each  AXIS controls; tuser constant 0.
REQ-016 tx_axis_tready  in  1  downstream MAC ready.

Function
REQ-017 States: IDLE, SEND, GAP; reset state IDLE.
REQ-018 IDLE: if arp_reply_req=1 -> latch recv_src_mac_addr/recv_src_ip_addr, op=0x0002, pulse arp_reply_ack, go SEND; else if arp_request_req=1 -> latch dst_ip_addr, op=0x0001, pulse arp_request_ack, go SEND.
REQ-019 Simultaneous reply and request: reply wins; request stays pending, served after GAP.
REQ-020 Ack pulses exactly one cycle per accepted frame; no ack outside IDLE.
REQ-021 First beat (tvalid=1) appears the cycle after acceptance; local_mac_addr/local_ip_addr also latched at acceptance.
REQ-022 Frame = 60 bytes, 8 beats, beat counter 0..7; beats 0-6 tkeep=0xFF, beat 7 tkeep=0x0F with tlast=1.
REQ-023 Byte map: 0-5 eth dst; 6-11 local MAC; 12-13 08 06; 14-15 00 01; 16-17 08 00; 18 06; 19 04; 20-21 op; 22-27 local MAC; 28-31 local IP; 32-37 target MAC; 38-41 target IP; 42-59 00.
REQ-024 Request: eth dst FF:FF:FF:FF:FF:FF, target MAC 0, target IP latched dst_ip. Reply: eth dst = target MAC = latched recv_src_mac, target IP = latched recv_src_ip.
REQ-025 Counter advances only on tvalid&tready; tdata/tkeep/tlast held stable while tready=0.
REQ-026 tlast beat accepted -> tvalid=0 next cycle, enter GAP for IFG_CYCLES cycles, then IDLE; IFG_CYCLES=0 -> directly IDLE.
REQ-027 Input changes after acceptance do not alter the frame in flight.
REQ-028 tvalid never deasserts mid-frame except by reset.

Reset
REQ-029 Reset asserted: tvalid=0, tlast=0, tkeep=0, tdata=0, tuser=0, both acks=0, counters=0, state IDLE, latches 0.
REQ-030 Reset mid-frame truncates frame immediately; no resume after release.
REQ-031 First acceptance possible the first clock after reset release.

Structure
REQ-032 Shared package holds ETHERTYPE_ARP 0x0806, ETHERTYPE_IPV4 0x0800, ARP_HTYPE_ETH 0x0001, ARP_OP_REQUEST 0x0001, ARP_OP_REPLY 0x0002, ARP_FRAME_BEATS 8, last-beat tkeep 0x0F.
REQ-033 Single module, no sub-module; beat data is an inline mux on beat counter.

Verification
REQ-034 Reply: local 00:0A:35:01:02:03/192.168.1.123, recv_src AC:14:74:45:BC:F4/192.168.1.101, reply_req=1, tready=1 -> ack 1 cycle, 8 beats, beat0 tdata=0x0A00F4BC457414AC, beat2 bytes4-5=00 02, beat7 tkeep=0x0F tlast=1.
REQ-035 Request: dst_ip 192.168.1.101 -> eth dst all FF, op 00 01, bytes 32-37 zero, bytes 38-41 C0 A8 01 65.
REQ-036 Backpressure: tready low on beats 3 and 7 for 5 cycles each -> data held, 8 beats total, no duplicates.
REQ-037 Both reqs same cycle -> reply frame first, request frame starts after 2 GAP cycles, each ack exactly once.
REQ-038 Reset asserted at beat 4 -> tvalid 0 immediately; after release, pending request yields complete 8-beat frame.
